// File: rtl/s_daas_seq.sv
// SPC700 DAA/DAS sequencer: latches A/PSW, drives the adjust unit, writes A and PSW back.
// Optional macro S_DAAS_SEQ_FAST_EN collapses the sequence to IDLE -> WB (latency 1).
module s_daas_seq #(
   parameter int unsigned LAT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_en,
   input  logic       req,
   input  logic       req_das,
   input  logic [7:0] a_in,
   input  logic [7:0] psw_in,
   output logic       busy,
   output logic [7:0] du_a,
   output logic [7:0] du_psw,
   output logic       du_ctl,
   input  logic [7:0] du_y,
   input  logic [4:0] du_flgs,
   output logic       a_we,
   output logic [7:0] a_wdata,
   output logic       psw_we,
   output logic [7:0] psw_wdata
);

   localparam int unsigned CW = 3;
`ifdef S_DAAS_SEQ_FAST_EN
   localparam int unsigned LAT_EFF = (LAT > 0) ? 1 : 1;
`else
   localparam int unsigned LAT_EFF = LAT;
`endif

   // du_flgs bit positions {N,V,H,Z,C}
   localparam int unsigned FLG_N = 4;
   localparam int unsigned FLG_Z = 1;
   localparam int unsigned FLG_C = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADJ  = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic           busy_q, busy_d;
   logic [7:0]     du_a_q, du_a_d;
   logic [7:0]     du_psw_q, du_psw_d;
   logic           du_ctl_q, du_ctl_d;
   logic           a_we_q, a_we_d;
   logic [7:0]     a_wdata_q, a_wdata_d;
   logic           psw_we_q, psw_we_d;
   logic [7:0]     psw_wdata_q, psw_wdata_d;
   logic           unused_flgs;

   // V and H from the adjust unit are not written back
   assign unused_flgs = ^du_flgs[3:2];

   // Next-state and registered-output logic; everything holds while cpu_en is low
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      busy_d      = busy_q;
      du_a_d      = du_a_q;
      du_psw_d    = du_psw_q;
      du_ctl_d    = du_ctl_q;
      a_we_d      = 1'b0;
      a_wdata_d   = a_wdata_q;
      psw_we_d    = 1'b0;
      psw_wdata_d = psw_wdata_q;
      if (cpu_en) begin
         case (state_q)
            IDLE: begin
               busy_d = 1'b0;
               if (req) begin
                  du_a_d   = a_in;
                  du_psw_d = psw_in;
                  du_ctl_d = req_das;
                  busy_d   = 1'b1;
                  count_d  = CW'(LAT_EFF - 1);
                  state_d  = (LAT_EFF <= 1) ? WB : ADJ;
               end
            end
            ADJ: begin
               count_d = count_q - CW'(1);
               if (count_q <= CW'(1)) begin
                  state_d = WB;
               end
            end
            WB: begin
               a_wdata_d   = du_y;
               psw_wdata_d = {du_flgs[FLG_N], du_psw_q[6:2], du_flgs[FLG_Z], du_flgs[FLG_C]};
               a_we_d      = 1'b1;
               psw_we_d    = 1'b1;
               state_d     = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         busy_q      <= 1'b0;
         du_a_q      <= 8'h00;
         du_psw_q    <= 8'h00;
         du_ctl_q    <= 1'b0;
         a_we_q      <= 1'b0;
         a_wdata_q   <= 8'h00;
         psw_we_q    <= 1'b0;
         psw_wdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         du_a_q      <= du_a_d;
         du_psw_q    <= du_psw_d;
         du_ctl_q    <= du_ctl_d;
         a_we_q      <= a_we_d;
         a_wdata_q   <= a_wdata_d;
         psw_we_q    <= psw_we_d;
         psw_wdata_q <= psw_wdata_d;
      end
   end

   assign busy      = busy_q;
   assign du_a      = du_a_q;
   assign du_psw    = du_psw_q;
   assign du_ctl    = du_ctl_q;
   assign a_we      = a_we_q;
   assign a_wdata   = a_wdata_q;
   assign psw_we    = psw_we_q;
   assign psw_wdata = psw_wdata_q;

endmodule
